// File: rtl/ex_muldiv_unit.sv
`default_nettype none
//============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the EX stage. Takes
//            operands and control from ID/EX and stalls the pipeline while
//            it iterates. It presents the result and destination register
//            to EX/MEM for one cycle on completion.
// Ports    : clk, reset (sync, active-high), flush (abort in-flight op),
//            start (valid M instruction in ID/EX), op (funct3),
//            rs1_data / rs2_data (operands), rd (destination),
//            stall (hold ID/EX and upstream), done (one-cycle valid pulse),
//            result, result_rd.
// Revision : 1.0 - initial release
//============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH         = 32,
    parameter bit ZERO_DIV_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [4:0]       rd,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_rd
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_op_lo;      // funct3[1:0]; funct3[2] is implied by the state
    logic [4:0]         r_rd;
    logic [WIDTH-1:0]   r_opb;        // |B|: multiplicand or divisor
    logic [2*WIDTH-1:0] r_acc;        // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic               r_neg_res;    // product / quotient must be negated
    logic               r_neg_rem;    // remainder must be negated
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_result_rd;

    // ---------------- issue-time operand conditioning ----------------
    logic             w_issue;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_zero_b;
    logic             w_fast_zero;

    assign w_issue     = start && !flush;
    assign w_a_signed  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_b_signed  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_neg_a     = w_a_signed && rs1_data[WIDTH-1];
    assign w_neg_b     = w_b_signed && rs2_data[WIDTH-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_mag_a     = w_neg_a ? -rs1_data : rs1_data;
    assign w_mag_b     = w_neg_b ? -rs2_data : rs2_data;
    assign w_zero_b    = (rs2_data == '0);
    assign w_fast_zero = ZERO_DIV_FAST && op[2] && w_zero_b;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: trial-subtract from the remainder shifted left by
    // one dividend bit; keep the difference only when it did not borrow.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {r_acc[2*WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // ---------------- final result selection ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_div_res;

    assign w_prod    = r_neg_res ? -w_mul_next : w_mul_next;
    assign w_mul_res = (r_op_lo == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    // Divide by zero leaves quotient all ones; sign correction must not touch it.
    assign w_quo     = r_div_zero ? '1
                     : (r_neg_res ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0]);
    assign w_rem     = r_neg_rem ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
    assign w_div_res = r_op_lo[1] ? w_rem : w_quo;

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_issue) begin
                    stall = 1'b1;
                    if (w_fast_zero) begin
                        w_state_next = c_S_DONE;
                    end else if (op[2]) begin
                        w_state_next = c_S_DIV;
                    end else begin
                        w_state_next = c_S_MUL;
                    end
                end
            end
            c_S_MUL, c_S_DIV: begin
                stall = 1'b1;
                if (r_count == c_LAST_CNT) begin
                    w_state_next = c_S_DONE;
                end
            end
            default: begin
                // DONE: the issuing instruction is still in ID/EX, so start is ignored.
                done         = 1'b1;
                w_state_next = c_S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_next = c_S_IDLE;
            done         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_op_lo     <= '0;
            r_rd        <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_div_zero  <= 1'b0;
            r_result    <= '0;
            r_result_rd <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_issue) begin
                        r_op_lo    <= op[1:0];
                        r_rd       <= rd;
                        r_opb      <= w_mag_b;
                        r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                        r_count    <= '0;
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_div_zero <= w_zero_b;
                    end
                end
                c_S_MUL: begin
                    r_acc   <= w_mul_next;
                    r_count <= r_count + c_CNT_ONE;
                end
                c_S_DIV: begin
                    r_acc   <= w_div_next;
                    r_count <= r_count + c_CNT_ONE;
                end
                default: begin
                end
            endcase

            // Result registers load only on entry to DONE (never under flush).
            if (w_state_next == c_S_DONE) begin
                if (r_state == c_S_IDLE) begin
                    r_result    <= op[1] ? rs1_data : '1;
                    r_result_rd <= rd;
                end else begin
                    r_result    <= (r_state == c_S_DIV) ? w_div_res : w_mul_res;
                    r_result_rd <= r_rd;
                end
            end
        end
    end

    assign result    = r_result;
    assign result_rd = r_result_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit: table of directed
//            vectors plus hand sequences for back-to-back, flush and reset.
// Revision : 1.0 - initial release
//============================================================================
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_rd;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;

    ex_muldiv_unit #(.WIDTH(32), .ZERO_DIV_FAST(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd        (rd),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .result_rd (result_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one operation at the current negedge and follow it to done.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic busy_ok;
        op       = v.op;
        rs1_data = v.a;
        rs2_data = v.b;
        rd       = v.rd;
        start    = 1'b1;
        #1;
        check($sformatf("v%0d_issue_stall", idx), {31'b0, stall}, 32'd1);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!stall) busy_ok = 1'b0;
        end
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_result", idx), result, v.exp);
        check($sformatf("v%0d_rd", idx), {27'b0, result_rd}, {27'b0, v.rd});
        check($sformatf("v%0d_stall_in_done", idx), {31'b0, stall}, 32'd0);
        check($sformatf("v%0d_stall_while_busy", idx), {31'b0, busy_ok}, 32'd1);
        last_result = v.exp;
        start = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", idx), {31'b0, done}, 32'd0);
    endtask

    // Run n cycles and return how many done pulses were seen.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int dcount;
        int d_cyc[2];
        logic [4:0]  d_rd[2];
        logic [31:0] d_res[2];

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 5'd10, 32'h0000_1234, 1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 33};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 33};
        vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd13, 32'hFFFF_FFFF, 33};
        vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd14, 32'h0000_0001, 33};
        vecs[14] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd15, 32'hFFFF_FFFB, 1};
        vecs[15] = '{3'd4, 32'h8000_0000, 32'h0000_0000, 5'd16, 32'hFFFF_FFFF, 1};
        vecs[16] = '{3'd4, 32'd20,        32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFFA, 33};
        vecs[17] = '{3'd6, 32'd20,        32'hFFFF_FFFD, 5'd18, 32'h0000_0002, 33};

        reset    = 1'b1;
        flush    = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        rs1_data = '0;
        rs2_data = '0;
        rd       = '0;
        last_result = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'b0, result_rd}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i], i);
        end

        // ---- back-to-back MUL then DIV, start held through DONE ----
        dcount = 0;
        d_cyc[0] = 0; d_cyc[1] = 0;
        d_rd[0] = '0; d_rd[1] = '0;
        d_res[0] = '0; d_res[1] = '0;
        op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; rd = 5'd3; start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) begin
                if (dcount < 2) begin
                    d_cyc[dcount] = c;
                    d_rd[dcount]  = result_rd;
                    d_res[dcount] = result;
                end
                dcount++;
                if (dcount == 2) start = 1'b0;
            end
            if (c == 34) begin
                op = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd9;
            end
        end
        start = 1'b0;
        check("b2b_pulses", dcount, 2);
        check("b2b_first_cycle", d_cyc[0], 33);
        check("b2b_gap", d_cyc[1] - d_cyc[0], 34);
        check("b2b_rd0", {27'b0, d_rd[0]}, 32'd3);
        check("b2b_rd1", {27'b0, d_rd[1]}, 32'd9);
        check("b2b_res0", d_res[0], 32'd15);
        check("b2b_res1", d_res[1], 32'd14);
        last_result = 32'd14;

        // ---- flush at t+10 of a DIV ----
        op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd20; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall_drop", {31'b0, stall}, 32'd0);
        count_done(40, dcount);
        check("flush_no_done", dcount, 0);
        check("flush_result_hold", result, last_result);
        check("flush_rd_hold", {27'b0, result_rd}, 32'd9);

        // ---- flush has priority over start in IDLE ----
        op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; rd = 5'd21; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_prio_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        count_done(40, dcount);
        check("flush_prio_no_done", dcount, 0);

        // ---- flush in DONE suppresses done ----
        op = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; rd = 5'd22; start = 1'b1;
        repeat (33) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_done_gated", {31'b0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        count_done(5, dcount);
        check("flush_done_no_late", dcount, 0);

        // ---- reset at t+5 of a MUL ----
        op = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd = 5'd23; start = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_stall", {31'b0, stall}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd", {27'b0, result_rd}, 32'd0);
        count_done(40, dcount);
        check("midreset_no_done", dcount, 0);

        // ---- next start after reset executes normally ----
        run_vec(vecs[13], 100);
        run_vec(vecs[8], 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage; consumes operands and control held in the ID/EX pipeline register.
- Asserts a stall that freezes ID/EX (and upstream stages) while an operation iterates.
- Presents the result and destination register to the EX/MEM register for exactly one cycle on completion.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- ZERO_DIV_FAST, 1, when 1, divide-by-zero completes without iterating.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  abort the in-flight operation (branch mispredict flush)
- start  input  1  ID/EX holds a valid M-extension instruction
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  input  WIDTH  operand A (forwarded value)
- rs2_data  input  WIDTH  operand B (forwarded value)
- rd  input  5  destination register
- stall  output  1  hold ID/EX and upstream registers
- done  output  1  one-cycle result-valid pulse
- result  output  WIDTH  product or quotient/remainder
- result_rd  output  5  destination register of result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state IDLE, stall 0, done 0, result 0, result_rd 0, counter 0, all datapath registers 0.
- States:
  - IDLE: if start && !flush, latch op, rd and operand magnitudes plus sign flags, then go to MUL (op<4) or DIV (op>=4). Exception: DIV/DIVU/REM/REMU with rs2_data==0 and ZERO_DIV_FAST=1 goes directly to DONE.
  - MUL: shift-add, one bit per cycle; 2*WIDTH-bit accumulator on magnitudes; counter runs 0..WIDTH-1, then DONE.
  - DIV: restoring division, one quotient bit per cycle on magnitudes; counter runs 0..WIDTH-1, then DONE.
  - DONE: done=1, result and result_rd valid; unconditionally returns to IDLE.
- stall = (state==IDLE && start && !flush) || state==MUL || state==DIV. It is combinational, so the issuing cycle already stalls, and stall is 0 in DONE so the pipeline advances on the DONE edge.
- start is ignored in DONE, because the same instruction is still present in ID/EX. start is only sampled in IDLE.
- Latency: start in cycle t; done in cycle t+WIDTH+1 (t+33 at default); divide-by-zero fast path gives done at t+1.
- Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned. DIV/REM are signed; DIVU/REMU are unsigned.
- Result selection:
  - MUL returns the low WIDTH bits of the product; MULH/MULHSU/MULHU return the high WIDTH bits.
  - Negate the product when the operand signs differ (signed interpretations only).
  - Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero (any path): quotient is all ones; remainder equals rs1_data. Signedness does not apply.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient 0x80000000, remainder 0. This must fall out of the iterative path or be special-cased; the result is not sign-corrupted.
- flush:
  - In any state, the next state is IDLE; done is suppressed and result/result_rd hold their values.
  - flush takes priority over start in the same cycle.
  - flush in DONE still suppresses done (done is gated by !flush).
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values; no done pulse.
- result/result_rd update only on entry to DONE and hold afterwards. Consumers must qualify them with done.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> done at t+33, result 0xFFFFFFEB; stall high from t through t+32, low at t+33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF at t+1; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-to-back MUL then DIV, start held through DONE -> exactly two done pulses, 34 cycles apart, correct rd on each.
- flush at t+10 of a DIV -> stall drops at t+11, no done. reset at t+5 of a MUL -> IDLE, outputs 0. Next start executes normally.
